// File: rtl/decode_pipe_elastic_if.sv
// Decode->execute stage bus: upstream beat (valid_i/ready_o + payload) and
// downstream beat (valid_o/ready_i + registered payload).
interface decode_pipe_elastic_if #(
    parameter int N     = 8,
    parameter int LANES = 16,
    parameter int RA_W  = 4
);
    logic                       valid_i, ready_o;
    logic [LANES-1:0][N-1:0]    rd1, rd2, extend;
    logic [RA_W-1:0]            ra1, ra2, WA3;
    logic [LANES-1:0]           lane_en;
    logic                       RegWrite, MemtoReg, MemWrite;
    logic [1:0]                 ALUSrc;
    logic [2:0]                 ALUControl;

    logic                       valid_o, ready_i;
    logic [LANES-1:0][N-1:0]    rd1o, rd2o, extendO;
    logic [RA_W-1:0]            ra1o, ra2o, WA3O;
    logic [LANES-1:0]           lane_enO;
    logic                       RegWriteO, MemtoRegO, MemWriteO;
    logic [1:0]                 ALUSrcO;
    logic [2:0]                 ALUControlO;

    modport slave (
        input  valid_i, rd1, rd2, extend, ra1, ra2, WA3, lane_en,
               RegWrite, MemtoReg, MemWrite, ALUSrc, ALUControl, ready_i,
        output ready_o, valid_o, rd1o, rd2o, extendO, ra1o, ra2o, WA3O, lane_enO,
               RegWriteO, MemtoRegO, MemWriteO, ALUSrcO, ALUControlO
    );

    modport master (
        output valid_i, rd1, rd2, extend, ra1, ra2, WA3, lane_en,
               RegWrite, MemtoReg, MemWrite, ALUSrc, ALUControl, ready_i,
        input  ready_o, valid_o, rd1o, rd2o, extendO, ra1o, ra2o, WA3O, lane_enO,
               RegWriteO, MemtoRegO, MemWriteO, ALUSrcO, ALUControlO
    );
endinterface

// File: rtl/decode_pipe_elastic.sv
// Elastic decode->execute register: main + skid buffer, flush, bubble-gated
// write strobes and a saturating downstream stall counter.
module decode_pipe_elastic #(
    parameter int N     = 8,
    parameter int LANES = 16,
    parameter int RA_W  = 4,
    parameter int CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    decode_pipe_elastic_if.slave   bus,
    output logic [CNT_W-1:0]       stall_cnt
);
    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

    typedef struct packed {
        logic [LANES-1:0][N-1:0] rd1;
        logic [LANES-1:0][N-1:0] rd2;
        logic [LANES-1:0][N-1:0] ext;
        logic [RA_W-1:0]         ra1;
        logic [RA_W-1:0]         ra2;
        logic [RA_W-1:0]         wa3;
        logic [LANES-1:0]        lane_en;
        logic                    reg_write;
        logic                    mem_to_reg;
        logic                    mem_write;
        logic [1:0]              alu_src;
        logic [2:0]              alu_ctrl;
    } payload_t;

    state_t           r_state;
    payload_t         r_main, r_skid;
    logic [CNT_W-1:0] r_stall;
    payload_t         w_in;
    logic             w_valid, w_ready, w_acc, w_xfer;

    assign w_in.rd1        = bus.rd1;
    assign w_in.rd2        = bus.rd2;
    assign w_in.ext        = bus.extend;
    assign w_in.ra1        = bus.ra1;
    assign w_in.ra2        = bus.ra2;
    assign w_in.wa3        = bus.WA3;
    assign w_in.lane_en    = bus.lane_en;
    assign w_in.reg_write  = bus.RegWrite;
    assign w_in.mem_to_reg = bus.MemtoReg;
    assign w_in.mem_write  = bus.MemWrite;
    assign w_in.alu_src    = bus.ALUSrc;
    assign w_in.alu_ctrl   = bus.ALUControl;

    // Handshake is decoded purely from registered state: no ready_i->ready_o path.
    assign w_valid = (r_state != EMPTY);
    assign w_ready = (r_state != FULL);
    assign w_acc   = bus.valid_i & w_ready;
    assign w_xfer  = w_valid & bus.ready_i;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= EMPTY;
            r_main  <= '0;
            r_skid  <= '0;
            r_stall <= '0;
        end else begin
            if (w_valid && !bus.ready_i && r_stall != '1)
                r_stall <= r_stall + 1'b1;
            if (flush) begin
                r_state <= EMPTY;
            end else begin
                case (r_state)
                    EMPTY: if (w_acc) begin
                        r_main  <= w_in;
                        r_state <= ONE;
                    end
                    ONE: case ({w_acc, w_xfer})
                        2'b11:   r_main <= w_in;
                        2'b10: begin
                            r_skid  <= w_in;
                            r_state <= FULL;
                        end
                        2'b01:   r_state <= EMPTY;
                        default: ;
                    endcase
                    FULL: if (w_xfer) begin
                        r_main  <= r_skid;
                        r_state <= ONE;
                    end
                    default: r_state <= EMPTY;
                endcase
            end
        end
    end

    assign bus.ready_o     = w_ready;
    assign bus.valid_o     = w_valid;
    assign bus.rd1o        = r_main.rd1;
    assign bus.rd2o        = r_main.rd2;
    assign bus.extendO     = r_main.ext;
    assign bus.ra1o        = r_main.ra1;
    assign bus.ra2o        = r_main.ra2;
    assign bus.WA3O        = r_main.wa3;
    assign bus.lane_enO    = r_main.lane_en;
    // Write strobes are killed in bubbles so a stale main never commits.
    assign bus.RegWriteO   = r_main.reg_write & w_valid;
    assign bus.MemWriteO   = r_main.mem_write & w_valid;
    assign bus.MemtoRegO   = r_main.mem_to_reg;
    assign bus.ALUSrcO     = r_main.alu_src;
    assign bus.ALUControlO = r_main.alu_ctrl;
    assign stall_cnt       = r_stall;
endmodule

// File: tb/tb_decode_pipe_elastic.sv
// Directed bench: default-parameter instance for reset/stream/backpressure/flush,
// narrow instance (N=16, LANES=4, RA_W=5, CNT_W=4) for saturation and random sweep.
module tb_decode_pipe_elastic;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, flush0, flush1;
    logic [15:0] st0;
    logic [3:0]  st1;
    int          vecs = 0;
    int          errs = 0;

    decode_pipe_elastic_if #(.N(8),  .LANES(16), .RA_W(4)) a ();
    decode_pipe_elastic_if #(.N(16), .LANES(4),  .RA_W(5)) b ();

    decode_pipe_elastic #(.N(8), .LANES(16), .RA_W(4), .CNT_W(16)) u0 (
        .clk(clk), .reset(reset), .flush(flush0), .bus(a), .stall_cnt(st0));
    decode_pipe_elastic #(.N(16), .LANES(4), .RA_W(5), .CNT_W(4)) u1 (
        .clk(clk), .reset(reset), .flush(flush1), .bus(b), .stall_cnt(st1));

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_a(input logic [7:0] t);
        a.rd1 = '0; a.rd2 = '0; a.extend = '0;
        a.rd1[0] = t; a.rd1[15] = t; a.rd2[0] = ~t; a.extend[0] = t + 8'd1;
        a.ra1 = t[3:0]; a.ra2 = t[7:4]; a.WA3 = ~t[3:0];
        a.lane_en = {t, ~t};
        a.RegWrite = 1'b1; a.MemtoReg = t[1]; a.MemWrite = t[0];
        a.ALUSrc = t[1:0]; a.ALUControl = t[2:0];
    endtask

    task automatic set_b(input logic [15:0] t);
        b.rd1 = '0; b.rd2 = '0; b.extend = '0;
        b.rd1[0] = t; b.rd2[3] = ~t;
        b.ra1 = t[4:0]; b.ra2 = t[9:5]; b.WA3 = t[14:10];
        b.lane_en = t[3:0] ^ t[7:4];
        b.RegWrite = 1'b1; b.MemtoReg = 1'b0; b.MemWrite = t[0];
        b.ALUSrc = 2'd0; b.ALUControl = 3'd0;
    endtask

    task automatic test_reset;
        reset = 1'b1; flush0 = 1'b0; flush1 = 1'b0;
        set_a(8'hA5); a.valid_i = 1'b1; a.ready_i = 1'b1;
        set_b(16'h1234); b.valid_i = 1'b1; b.ready_i = 1'b1;
        tick; tick;
        vecs++; if (a.valid_o !== 1'b0) begin errs++; $display("FAIL reset_valid_o: got %0b want 0", a.valid_o); end
        vecs++; if (a.ready_o !== 1'b1) begin errs++; $display("FAIL reset_ready_o: got %0b want 1", a.ready_o); end
        vecs++; if (a.rd1o !== '0) begin errs++; $display("FAIL reset_rd1o: got %0h want 0", a.rd1o); end
        vecs++; if (a.extendO !== '0) begin errs++; $display("FAIL reset_extendO: got %0h want 0", a.extendO); end
        vecs++; if (a.lane_enO !== 16'h0) begin errs++; $display("FAIL reset_lane_enO: got %0h want 0", a.lane_enO); end
        vecs++; if (a.WA3O !== 4'h0 || a.ALUControlO !== 3'd0) begin errs++; $display("FAIL reset_ctrl: got %0h/%0h want 0/0", a.WA3O, a.ALUControlO); end
        vecs++; if (a.RegWriteO !== 1'b0 || a.MemWriteO !== 1'b0) begin errs++; $display("FAIL reset_strobes: got %0b%0b want 00", a.RegWriteO, a.MemWriteO); end
        vecs++; if (st0 !== 16'd0) begin errs++; $display("FAIL reset_stall_cnt: got %0d want 0", st0); end
        vecs++; if (b.valid_o !== 1'b0 || b.ready_o !== 1'b1 || st1 !== 4'd0) begin errs++; $display("FAIL reset_b: got v%0b r%0b s%0d want v0 r1 s0", b.valid_o, b.ready_o, st1); end
        reset = 1'b0; a.valid_i = 1'b0; b.valid_i = 1'b0;
    endtask

    task automatic test_streaming;
        logic [7:0] t;
        a.ready_i = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            t = i[7:0];
            set_a(t); a.valid_i = 1'b1;
            tick;
            vecs++; if (a.valid_o !== 1'b1 || a.rd1o[0] !== t || a.rd1o[15] !== t) begin errs++; $display("FAIL stream_beat%0d: got v%0b %0h want v1 %0h", i, a.valid_o, a.rd1o[0], t); end
            vecs++; if (a.extendO[0] !== t + 8'd1 || a.WA3O !== ~t[3:0] || a.lane_enO !== {t, ~t}) begin errs++; $display("FAIL stream_fields%0d: got %0h %0h %0h", i, a.extendO[0], a.WA3O, a.lane_enO); end
        end
        vecs++; if (st0 !== 16'd0) begin errs++; $display("FAIL stream_stall_cnt: got %0d want 0", st0); end
        a.valid_i = 1'b0;
        tick;
        vecs++; if (a.valid_o !== 1'b0 || a.RegWriteO !== 1'b0) begin errs++; $display("FAIL stream_drain: got v%0b rw%0b want v0 rw0", a.valid_o, a.RegWriteO); end
    endtask

    task automatic test_backpressure;
        set_a(8'h41); a.valid_i = 1'b1; a.ready_i = 1'b1;
        tick;
        set_a(8'h42); a.ready_i = 1'b0;
        tick;
        vecs++; if (a.ready_o !== 1'b0 || a.valid_o !== 1'b1 || a.rd1o[0] !== 8'h41) begin errs++; $display("FAIL bp_full: got r%0b v%0b %0h want r0 v1 41", a.ready_o, a.valid_o, a.rd1o[0]); end
        set_a(8'h43);
        tick; tick;
        vecs++; if (st0 !== 16'd3) begin errs++; $display("FAIL bp_stall_cnt: got %0d want 3", st0); end
        vecs++; if (a.rd1o[0] !== 8'h41 || a.ready_o !== 1'b0) begin errs++; $display("FAIL bp_hold: got %0h r%0b want 41 r0", a.rd1o[0], a.ready_o); end
        a.valid_i = 1'b0; a.ready_i = 1'b1;
        tick;
        vecs++; if (a.valid_o !== 1'b1 || a.rd1o[0] !== 8'h42 || a.ready_o !== 1'b1) begin errs++; $display("FAIL bp_skid: got v%0b %0h r%0b want v1 42 r1", a.valid_o, a.rd1o[0], a.ready_o); end
        tick;
        vecs++; if (a.valid_o !== 1'b0 || a.rd1o[0] !== 8'h42) begin errs++; $display("FAIL bp_empty: got v%0b %0h want v0 42", a.valid_o, a.rd1o[0]); end
        vecs++; if (st0 !== 16'd3) begin errs++; $display("FAIL bp_stall_keep: got %0d want 3", st0); end
    endtask

    task automatic test_flush;
        set_a(8'h51); a.valid_i = 1'b1; a.ready_i = 1'b0;
        tick;
        set_a(8'h52);
        tick;
        vecs++; if (a.ready_o !== 1'b0 || st0 !== 16'd4) begin errs++; $display("FAIL flush_pre: got r%0b s%0d want r0 s4", a.ready_o, st0); end
        set_a(8'h53); flush0 = 1'b1; a.ready_i = 1'b1;
        tick;
        flush0 = 1'b0; a.valid_i = 1'b0;
        vecs++; if (a.valid_o !== 1'b0 || a.ready_o !== 1'b1) begin errs++; $display("FAIL flush_state: got v%0b r%0b want v0 r1", a.valid_o, a.ready_o); end
        vecs++; if (a.RegWriteO !== 1'b0 || a.MemWriteO !== 1'b0) begin errs++; $display("FAIL flush_gating: got %0b%0b want 00", a.RegWriteO, a.MemWriteO); end
        vecs++; if (a.rd1o[0] !== 8'h51 || st0 !== 16'd4) begin errs++; $display("FAIL flush_hold: got %0h s%0d want 51 s4", a.rd1o[0], st0); end
        tick; tick;
        vecs++; if (a.valid_o !== 1'b0 || a.rd1o[0] !== 8'h51) begin errs++; $display("FAIL flush_dropped: got v%0b %0h want v0 51", a.valid_o, a.rd1o[0]); end
        set_a(8'h61); a.valid_i = 1'b1;
        tick;
        a.valid_i = 1'b0;
        vecs++; if (a.valid_o !== 1'b1 || a.rd1o[0] !== 8'h61 || a.MemWriteO !== 1'b1) begin errs++; $display("FAIL flush_recover: got v%0b %0h mw%0b want v1 61 mw1", a.valid_o, a.rd1o[0], a.MemWriteO); end
        tick;
    endtask

    task automatic test_saturation;
        set_b(16'h0007); b.valid_i = 1'b1; b.ready_i = 1'b0;
        tick;
        b.valid_i = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            tick;
            if (k == 14) begin vecs++; if (st1 !== 4'd14) begin errs++; $display("FAIL sat_14: got %0d want 14", st1); end end
            if (k == 15) begin vecs++; if (st1 !== 4'd15) begin errs++; $display("FAIL sat_15: got %0d want 15", st1); end end
        end
        vecs++; if (st1 !== 4'd15) begin errs++; $display("FAIL sat_hold: got %0d want 15", st1); end
        vecs++; if (b.valid_o !== 1'b1 || b.rd1o[0] !== 16'h0007) begin errs++; $display("FAIL sat_beat: got v%0b %0h want v1 7", b.valid_o, b.rd1o[0]); end
        b.ready_i = 1'b1;
        tick;
        vecs++; if (b.valid_o !== 1'b0 || st1 !== 4'd15) begin errs++; $display("FAIL sat_drain: got v%0b s%0d want v0 s15", b.valid_o, st1); end
    endtask

    task automatic test_sweep;
        logic [15:0] q_tag[$];
        logic [3:0]  q_en[$];
        logic [15:0] tag;
        logic        vi, ri, acc, xfer;
        int          delivered;
        tag = 16'h0100; delivered = 0;
        for (int c = 0; c < 1000; c++) begin
            vecs++; if (b.valid_o !== (q_tag.size() > 0) || b.ready_o !== (q_tag.size() < 2)) begin errs++; $display("FAIL sweep_hs c%0d: got v%0b r%0b occ %0d", c, b.valid_o, b.ready_o, q_tag.size()); end
            vecs++; if (b.RegWriteO !== (q_tag.size() > 0)) begin errs++; $display("FAIL sweep_rw c%0d: got %0b occ %0d", c, b.RegWriteO, q_tag.size()); end
            if (q_tag.size() > 0) begin
                vecs++; if (b.rd1o[0] !== q_tag[0] || b.lane_enO !== q_en[0]) begin errs++; $display("FAIL sweep_data c%0d: got %0h/%0h want %0h/%0h", c, b.rd1o[0], b.lane_enO, q_tag[0], q_en[0]); end
            end
            vi = 1'($urandom_range(0, 1)); ri = 1'($urandom_range(0, 1));
            set_b(tag); b.valid_i = vi; b.ready_i = ri;
            acc  = vi && (q_tag.size() < 2);
            xfer = ri && (q_tag.size() > 0);
            if (xfer) begin void'(q_tag.pop_front()); void'(q_en.pop_front()); delivered++; end
            if (acc) begin q_tag.push_back(tag); q_en.push_back(tag[3:0] ^ tag[7:4]); tag = tag + 16'd1; end
            tick;
        end
        b.valid_i = 1'b0; b.ready_i = 1'b1;
        tick; tick; tick;
        vecs++; if (b.valid_o !== 1'b0 || delivered < 100) begin errs++; $display("FAIL sweep_end: got v%0b delivered %0d want v0 >=100", b.valid_o, delivered); end
    endtask

    initial begin
        test_reset;
        test_streaming;
        test_backpressure;
        test_flush;
        test_saturation;
        test_sweep;
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule

// File: doc/decode_pipe_elastic.md
# decode_pipe_elastic

Parametrised decode→execute pipeline register for the vector CPU, the successor to the fixed 16×8-bit decode stage register. It carries LANES×N-bit operand vectors, register addresses, the extended immediate vector and the execute-stage control bundle. It adds a valid/ready handshake with a 2-entry skid buffer, synchronous flush, lane-enable mask passthrough, bubble gating of write strobes and a saturating stall counter.

## Interface
- N, 8, element width in bits
- LANES, 16, vector lanes per operand
- RA_W, 4, register address width (ra1, ra2, WA3)
- CNT_W, 16, stall counter width
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- flush  in  1  synchronous kill of all buffered beats
- valid_i  in  1  upstream beat valid
- ready_o  out  1  stage can accept a beat this cycle
- rd1, rd2, extend  in  LANES×N each  operand A, operand B, extended immediate
- ra1, ra2, WA3  in  RA_W each  source and destination addresses
- lane_en  in  LANES  per-lane enable mask
- RegWrite, MemtoReg, MemWrite  in  1 each  control bits
- ALUSrc  in  2  ALU operand select
- ALUControl  in  3  ALU operation
- valid_o  out  1  output beat valid
- ready_i  in  1  downstream accepts the beat
- rd1o, rd2o, extendO, ra1o, ra2o, WA3O, lane_enO, RegWriteO, MemtoRegO, MemWriteO, ALUSrcO, ALUControlO  out  matching input widths  registered payload
- stall_cnt  out  CNT_W  cycles with valid_o=1 and ready_i=0, saturating

## Operation
- Storage: main register, which drives the outputs, and a skid register, each holding the full payload.
- States:
  - EMPTY: main invalid.
  - ONE: main valid, skid empty.
  - FULL: both valid.
- ready_o = (state != FULL). It is decoded from registered state only and never depends on ready_i.
- valid_o = (state != EMPTY).
- Input accept = valid_i & ready_o. Output transfer = valid_o & ready_i.
- EMPTY: accept → main←input, go to ONE.
- ONE, accept and transfer → main←input, stay in ONE.
- ONE, accept and no transfer → skid←input, go to FULL.
- ONE, no accept and transfer → go to EMPTY.
- ONE, neither → hold.
- FULL, transfer → main←skid, go to ONE. Input is ignored because ready_o=0.
- FULL, no transfer → hold.
- Bubble gating: RegWriteO and MemWriteO are forced to 0 whenever valid_o=0. All other payload outputs hold their last main value when EMPTY.
- Flush (priority below reset, above all other events):
  - State goes to EMPTY and the skid is discarded.
  - A beat accepted in the flush cycle is dropped.
  - Main payload is not cleared; bubble gating applies.
  - stall_cnt is unaffected.
- stall_cnt increments when valid_o & ~ready_i, saturates at 2^CNT_W−1, and clears only on reset.
- Reset: state EMPTY; all payload registers, lane_enO and stall_cnt to 0.
- Outputs after reset: valid_o=0, ready_o=1.

## Timing
- Latency: a beat accepted at edge k appears on the outputs after edge k, with valid_o=1 in cycle k+1.
- Throughput: 1 beat/cycle while ready_i=1.
- No combinational path from ready_i to ready_o, or from valid_i to valid_o.
- The skid register absorbs exactly the one beat already in flight when ready_i drops. ready_o falls the cycle after entering FULL.
- Drain from FULL with ready_i=1 takes 2 cycles: skid beat, then EMPTY or a new beat.
- reset and flush are sampled only on the clk edge. reset mid-stream loses all beats; flush mid-stream loses all beats and keeps stall_cnt.
- Payload ordering is strictly FIFO: a skid beat always precedes any later input.

## Test plan
- Reset: assert reset 2 cycles with valid_i=1 → valid_o=0, ready_o=1, all payload 0, stall_cnt=0.
- Streaming: valid_i=1, ready_i=1 for 20 beats with rd1 lane0=0x01..0x14 → outputs appear 1 cycle later in order, no gaps, stall_cnt stays 0.
- Backpressure: beat A accepted; ready_i=0 while B is sent → FULL, ready_o=0 next cycle. Hold 3 cycles → stall_cnt=3, A held on outputs. ready_i=1 → A then B delivered, state returns to EMPTY.
- Flush: FULL with beats A,B; flush=1 with valid_i=1 (beat C) → next cycle valid_o=0, RegWriteO=MemWriteO=0, C not delivered, stall_cnt unchanged.
- Saturation: CNT_W=4, hold valid_o=1 and ready_i=0 for 20 cycles → stall_cnt=15 and holds.
- Parameter sweep: N=16, LANES=4, RA_W=5 with random valid_i/ready_i over 1000 cycles → scoreboard shows in-order, lossless delivery with lane_enO matching each beat.
